// File: rtl/note_detector_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_detector_pkg                                                          |
// | Shared note table and threshold helpers for the note detector and for any |
// | tone generator that has to produce the same nominal pitches.              |
// |   NOTE_COUNT   : number of detectable notes (C4..C5)                       |
// |   note_e       : note index encoding (matches the note_idx output)        |
// |   note_hz()    : nominal frequency of a note in Hz                         |
// |   note_period(): nominal period in clock cycles, rounded to nearest       |
// |   note_lo/hi() : inclusive lower / exclusive upper period bound of a band |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package note_detector_pkg;

  localparam int NOTE_COUNT = 8;

  typedef enum logic [2:0] {
    NOTE_C4 = 3'd0,
    NOTE_D4 = 3'd1,
    NOTE_E4 = 3'd2,
    NOTE_F4 = 3'd3,
    NOTE_G4 = 3'd4,
    NOTE_A4 = 3'd5,
    NOTE_B4 = 3'd6,
    NOTE_C5 = 3'd7
  } note_e;

  function automatic int note_hz(input int idx);
    case (idx)
      0:       return 262;
      1:       return 294;
      2:       return 330;
      3:       return 349;
      4:       return 392;
      5:       return 440;
      6:       return 494;
      default: return 523;
    endcase
  endfunction

  function automatic int note_period(input int clk_hz, input int idx);
    int hz;
    hz = note_hz(idx);
    return (clk_hz + hz / 2) / hz;
  endfunction

  // Periods shrink as the index rises, so a band's lower period bound sits
  // towards the next higher note and its upper bound towards the next lower.
  function automatic int note_lo(input int clk_hz, input int idx);
    if (idx >= NOTE_COUNT - 1)
      return (note_period(clk_hz, idx) * 94) / 100;
    return (note_period(clk_hz, idx) + note_period(clk_hz, idx + 1)) / 2;
  endfunction

  function automatic int note_hi(input int clk_hz, input int idx);
    if (idx <= 0)
      return (note_period(clk_hz, idx) * 106) / 100;
    return (note_period(clk_hz, idx - 1) + note_period(clk_hz, idx)) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_detector_edge_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | edge_sync                                                                  |
// | Two-flop synchronizer followed by a rising-edge detector.                 |
// |   osc  : clock                                                            |
// |   rst  : asynchronous active-high reset                                   |
// |   d    : asynchronous input                                               |
// |   rise : one-cycle pulse on a synchronized 0->1 transition                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module edge_sync (
  input  logic osc,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic       s1_q;
  logic       s2_q;
  logic       prev_q;
  logic [2:0] fill_q;

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      fill_q <= 3'b000;
    end else begin
      s1_q   <= d;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  // Until prev_q holds a real sample, a high input would look like an edge
  // against the cleared reset value; mask it so release mid-tone is silent.
  assign rise = s2_q & ~prev_q & fill_q[2];

endmodule
`default_nettype wire

// File: rtl/note_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | note_detector                                                              |
// | Measures the rising-to-rising period of a square-wave tone and classifies |
// | it against the C4..C5 note bands.                                          |
// |   osc        : clock, all logic on rising edge                            |
// |   rst        : asynchronous active-high reset                             |
// |   tone_in    : asynchronous tone input                                    |
// |   period     : last measured period in osc cycles                         |
// |   period_stb : one-cycle pulse when period updates                        |
// |   note_idx   : detected note (note_e encoding), held while not valid      |
// |   note_valid : note_idx is a currently detected note                      |
// | Build option: define NOTE_DETECTOR_STABLE_EN to require STABLE_CNT         |
// | consecutive identical matches before the reported note changes.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module note_detector
  import note_detector_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PERIOD_W   = 20,
  parameter int STABLE_CNT = 4
) (
  input  logic                osc,
  input  logic                rst,
  input  logic                tone_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_stb,
  output logic [2:0]          note_idx,
  output logic                note_valid
);

  localparam logic [PERIOD_W-1:0] CNT_ONE     = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] CNT_MAX     = {PERIOD_W{1'b1}};
  localparam logic [PERIOD_W-1:0] CNT_PRE_SAT = CNT_MAX - CNT_ONE;

  // A 3-bit stability count can never reach a threshold outside 1..7.
  if (STABLE_CNT < 1 || STABLE_CNT > 7) begin : g_bad_stable_cnt
    $error("note_detector: STABLE_CNT must be in 1..7");
  end

  logic w_rise;

  edge_sync u_edge_sync (
    .osc  (osc),
    .rst  (rst),
    .d    (tone_in),
    .rise (w_rise)
  );

  logic [PERIOD_W-1:0] cnt_q,      cnt_d;
  logic                armed_q,    armed_d;
  logic [PERIOD_W-1:0] period_q,   period_d;
  logic                stb_q,      stb_d;
  note_e               note_idx_q, note_idx_d;
  logic                valid_q,    valid_d;

`ifdef NOTE_DETECTOR_STABLE_EN
  localparam logic [2:0] STABLE_TH = 3'(STABLE_CNT);
  logic [2:0] stab_q, stab_d;
  note_e      cand_q, cand_d;
  logic [2:0] w_stab_next;
`endif

  // Band classification of the registered period.
  logic [NOTE_COUNT-1:0] w_hit;

  for (genvar k = 0; k < NOTE_COUNT; k++) begin : g_band
    localparam logic [31:0] LO = 32'(note_lo(CLK_HZ, k));
    localparam logic [31:0] HI = 32'(note_hi(CLK_HZ, k));
    assign w_hit[k] = (32'(period_q) >= LO) && (32'(period_q) < HI);
  end

  logic  w_match;
  note_e w_match_idx;

  // Bands are disjoint, so at most one bit of w_hit is set.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = NOTE_C4;
    for (int k = 0; k < NOTE_COUNT; k++) begin
      if (w_hit[k]) begin
        w_match     = 1'b1;
        w_match_idx = note_e'(3'(k));
      end
    end
  end

  // Saturation happens on the edge where cnt steps from MAX-1 to MAX.
  logic w_sat;
  assign w_sat = armed_q && (cnt_q == CNT_PRE_SAT);

  always_comb begin
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    period_d   = period_q;
    stb_d      = 1'b0;
    note_idx_d = note_idx_q;
    valid_d    = valid_q;
`ifdef NOTE_DETECTOR_STABLE_EN
    stab_d      = stab_q;
    cand_d      = cand_q;
    w_stab_next = 3'd0;
`endif

    // Period measurement; an edge on the saturating cycle only re-arms.
    if (w_rise) begin
      cnt_d   = CNT_ONE;
      armed_d = 1'b1;
      if (armed_q && !w_sat) begin
        period_d = cnt_q;
        stb_d    = 1'b1;
      end
    end else if (armed_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    // Classify the period published on the previous cycle.
    if (stb_q) begin
      if (!w_match) begin
        valid_d = 1'b0;
`ifdef NOTE_DETECTOR_STABLE_EN
        stab_d  = 3'd0;
`endif
      end else begin
`ifdef NOTE_DETECTOR_STABLE_EN
        if (w_match_idx == cand_q) begin
          w_stab_next = (stab_q == 3'd7) ? 3'd7 : stab_q + 3'd1;
        end else begin
          w_stab_next = 3'd1;
          cand_d      = w_match_idx;
        end
        stab_d = w_stab_next;
        if (w_stab_next >= STABLE_TH) begin
          note_idx_d = w_match_idx;
          valid_d    = 1'b1;
        end
`else
        note_idx_d = w_match_idx;
        valid_d    = 1'b1;
`endif
      end
    end

    // Silence: the tone has been absent for a full counter range.
    if (w_sat) begin
      valid_d = 1'b0;
      if (!w_rise) begin
        armed_d = 1'b0;
      end
`ifdef NOTE_DETECTOR_STABLE_EN
      stab_d = 3'd0;
`endif
    end
  end

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      period_q   <= '0;
      stb_q      <= 1'b0;
      note_idx_q <= NOTE_C4;
      valid_q    <= 1'b0;
`ifdef NOTE_DETECTOR_STABLE_EN
      stab_q     <= 3'd0;
      cand_q     <= NOTE_C4;
`endif
    end else begin
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      period_q   <= period_d;
      stb_q      <= stb_d;
      note_idx_q <= note_idx_d;
      valid_q    <= valid_d;
`ifdef NOTE_DETECTOR_STABLE_EN
      stab_q     <= stab_d;
      cand_q     <= cand_d;
`endif
    end
  end

  assign period     = period_q;
  assign period_stb = stb_q;
  assign note_idx   = note_idx_q;
  assign note_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_note_detector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_note_detector                                                           |
// | Directed bench for note_detector at CLK_HZ=1 MHz, PERIOD_W=16,             |
// | STABLE_CNT=4. Expectations follow NOTE_DETECTOR_STABLE_EN when defined.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_note_detector;
  import note_detector_pkg::*;

  localparam int CLK_HZ = 1_000_000;

`ifdef NOTE_DETECTOR_STABLE_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  logic        osc;
  logic        rst;
  logic        tone_in;
  logic [15:0] period;
  logic        period_stb;
  logic [2:0]  note_idx;
  logic        note_valid;

  int n_vec;
  int n_err;

  note_detector #(
    .CLK_HZ     (CLK_HZ),
    .PERIOD_W   (16),
    .STABLE_CNT (4)
  ) dut (
    .osc        (osc),
    .rst        (rst),
    .tone_in    (tone_in),
    .period     (period),
    .period_stb (period_stb),
    .note_idx   (note_idx),
    .note_valid (note_valid)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Raise tone_in now (on a falling clock edge), keep it high for half the
  // gap, then low, and return exactly gap cycles later. The strobe for this
  // edge is expected on the third falling edge; rst_at>0 pulses rst mid-gap.
  task automatic tone_step(input int gap, input bit exp_stb, input int exp_per,
                           input int rst_at, input string tag);
    tone_in = 1'b1;
    for (int i = 1; i <= gap; i++) begin
      @(negedge osc);
      if (i == gap / 2) tone_in = 1'b0;
      if (i == 2) check({tag, "_stb_early"}, period_stb, 0);
      if (i == 3) begin
        check({tag, "_stb"}, period_stb, exp_stb);
        if (exp_stb) check({tag, "_period"}, period, exp_per);
      end
      if (i == 4) check({tag, "_stb_width"}, period_stb, 0);
      if (rst_at > 0) begin
        if (i == rst_at) rst = 1'b1;
        if (i == rst_at + 2) begin
          check({tag, "_in_rst_period"}, period, 0);
          check({tag, "_in_rst_stb"}, period_stb, 0);
          check({tag, "_in_rst_idx"}, note_idx, 0);
          check({tag, "_in_rst_valid"}, note_valid, 0);
        end
        if (i == rst_at + 4) rst = 1'b0;
      end
    end
  endtask

  initial begin
    int p_a4, p_g4, p_e4, p_f4;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    tone_in = 1'b0;
    p_a4 = note_period(CLK_HZ, 5);
    p_g4 = note_period(CLK_HZ, 4);
    p_e4 = note_period(CLK_HZ, 2);
    p_f4 = note_period(CLK_HZ, 3);

    repeat (3) @(negedge osc);
    check("reset_period", period, 0);
    check("reset_stb", period_stb, 0);
    check("reset_idx", note_idx, 0);
    check("reset_valid", note_valid, 0);
    rst = 1'b0;
    repeat (5) @(negedge osc);

    // A4: arming edge then four measured periods of 2273.
    tone_step(p_a4, 1'b0, 0, 0, "a4_arm");
    for (int k = 1; k <= 4; k++) begin
      tone_step((k < 4) ? p_a4 : p_g4, 1'b1, 2273, 0, "a4");
      check("a4_valid", note_valid, (!STAB || k >= 4) ? 1 : 0);
      check("a4_idx", note_idx, (!STAB || k >= 4) ? 5 : 0);
    end

    // Switch to G4 (2551): the old note stays reported until G4 is stable.
    for (int k = 1; k <= 4; k++) begin
      tone_step(p_g4, 1'b1, 2551, 0, "g4");
      check("g4_valid", note_valid, 1);
      check("g4_idx", note_idx, (STAB && k < 4) ? 5 : 4);
    end

    // Silence: counter saturates 65537 cycles after the last raw edge.
    repeat (65536 - p_g4) @(negedge osc);
    check("sil_valid_before", note_valid, 1);
    @(negedge osc);
    check("sil_valid", note_valid, 0);
    check("sil_idx", note_idx, 4);
    check("sil_stb", period_stb, 0);

    // 100 Hz: needs an arming edge after silence, then period 10000, no note.
    tone_step(10000, 1'b0, 0, 0, "lo_arm");
    tone_step(p_a4, 1'b1, 10000, 0, "lo");
    check("lo_valid", note_valid, 0);
    check("lo_idx", note_idx, 4);

    // A4 edge, then rst pulsed mid-period while tone_in is high.
    tone_step(p_a4, 1'b1, 2273, 1000, "a4_rst");
    check("rst_period_held", period, 0);
    tone_step(p_e4, 1'b0, 0, 0, "rearm");
    check("rearm_period", period, 0);
    check("rearm_valid", note_valid, 0);

    // Alternating E4 / F4 periods.
    for (int k = 1; k <= 4; k++) begin
      tone_step((k == 4) ? 100 : ((k % 2 == 1) ? p_f4 : p_e4), 1'b1,
                (k % 2 == 1) ? 3030 : 2865, 0, "ef");
      check("ef_valid", note_valid, STAB ? 0 : 1);
      check("ef_idx", note_idx, STAB ? 0 : ((k % 2 == 1) ? 2 : 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
